// File: rtl/alarm_compare_multi.sv
// Multi-channel alarm compare controller.
// A scanner checks one channel per cycle against a time snapshot taken on each tick.
// A ringer presents the lowest-index pending channel until ack or timeout.
module alarm_compare_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned TW       = 17,
  parameter int unsigned RING_LEN = 8,
  localparam int unsigned CHW     = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [TW-1:0]  cur_time,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [TW-1:0]  cfg_time,
  input  logic           cfg_en,
  input  logic           ack,
  output logic           alarm,
  output logic [CHW-1:0] alarm_ch,
  output logic [NCH-1:0] pending,
  output logic           busy,
  output logic           overrun
);

  localparam int unsigned CNTW = $clog2(RING_LEN + 1);

  typedef enum logic {StIdle, StScan} scan_e;
  typedef enum logic {StQuiet, StRing} ring_e;

  logic [TW-1:0]   time_q [NCH];
  logic [NCH-1:0]  en_q;
  logic [NCH-1:0]  pending_q, pending_d;

  scan_e           scan_q, scan_d;
  logic [TW-1:0]   snap_q, snap_d;
  logic [CHW-1:0]  idx_q, idx_d;
  logic            overrun_q, overrun_d;
  logic [NCH-1:0]  scan_set_mask;

  ring_e           ring_q, ring_d;
  logic [CHW-1:0]  alarm_ch_q, alarm_ch_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  ring_clr_mask;

  logic            cfg_valid;
  logic [NCH-1:0]  cfg_clr_mask;
  logic [NCH-1:0]  pend_avail;
  logic [CHW-1:0]  sel;

  // Out-of-range channel writes are dropped; no check needed when NCH fills the index space
  if (2 ** CHW == NCH) begin : g_full_idx
    assign cfg_valid = cfg_we;
  end else begin : g_part_idx
    assign cfg_valid = cfg_we && (32'(cfg_ch) < NCH);
  end

  // Config write also clears the channel's pending bit, with priority over a scanner set
  always_comb begin
    cfg_clr_mask = '0;
    if (cfg_valid) cfg_clr_mask[cfg_ch] = 1'b1;
  end

  // Alarm time and enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) time_q[i] <= '0;
      en_q <= '0;
    end else if (cfg_valid) begin
      time_q[cfg_ch] <= cfg_time;
      en_q[cfg_ch]   <= cfg_en;
    end
  end

  // Scanner next-state: snapshot on tick, then one channel compare per cycle
  always_comb begin
    scan_d        = scan_q;
    snap_d        = snap_q;
    idx_d         = idx_q;
    overrun_d     = overrun_q;
    scan_set_mask = '0;
    unique case (scan_q)
      StIdle: begin
        if (tick) begin
          snap_d = cur_time;
          idx_d  = '0;
          scan_d = StScan;
        end
      end
      StScan: begin
        if (tick) overrun_d = 1'b1;
        if (en_q[idx_q] && (time_q[idx_q] == snap_q)) scan_set_mask[idx_q] = 1'b1;
        if (idx_q == CHW'(NCH - 1)) scan_d = StIdle;
        else                        idx_d  = idx_q + CHW'(1);
      end
      default: scan_d = StIdle;
    endcase
  end

  // Scanner state register
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= StIdle;
      snap_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      scan_q    <= scan_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Lowest-index pending channel, ignoring one being cleared by config this cycle
  always_comb begin
    pend_avail = pending_q & ~cfg_clr_mask;
    sel        = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (pend_avail[i]) sel = CHW'(i);
    end
  end

  // Ringer next-state: tick counts before the timeout compare
  always_comb begin
    ring_d        = ring_q;
    alarm_ch_d    = alarm_ch_q;
    cnt_d         = cnt_q;
    ring_clr_mask = '0;
    unique case (ring_q)
      StQuiet: begin
        if (|pend_avail) begin
          ring_d     = StRing;
          alarm_ch_d = sel;
          cnt_d      = '0;
        end
      end
      StRing: begin
        if (tick) cnt_d = cnt_q + CNTW'(1);
        if (cfg_valid && (cfg_ch == alarm_ch_q)) begin
          ring_d = StQuiet;
        end else if (ack || (cnt_d == CNTW'(RING_LEN))) begin
          ring_clr_mask[alarm_ch_q] = 1'b1;
          ring_d                    = StQuiet;
        end
      end
      default: ring_d = StQuiet;
    endcase
  end

  // Ringer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q     <= StQuiet;
      alarm_ch_q <= '0;
      cnt_q      <= '0;
    end else begin
      ring_q     <= ring_d;
      alarm_ch_q <= alarm_ch_d;
      cnt_q      <= cnt_d;
    end
  end

  // Pending merge: ringer clear < scanner set < config clear
  always_comb begin
    pending_d = ((pending_q & ~ring_clr_mask) | scan_set_mask) & ~cfg_clr_mask;
  end

  // Pending register
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign alarm    = (ring_q == StRing);
  assign alarm_ch = alarm_ch_q;
  assign pending  = pending_q;
  assign busy     = (scan_q == StScan);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_alarm_compare_multi.sv
// Directed bench for alarm_compare_multi: per-cycle vector table plus hand sequences.
module tb_alarm_compare_multi;

  localparam int NCH = 4;
  localparam int TW  = 17;
  localparam int RL  = 8;
  localparam int CHW = 2;

  logic           clk;
  logic           rst;
  logic           tick;
  logic [TW-1:0]  cur_time;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [TW-1:0]  cfg_time;
  logic           cfg_en;
  logic           ack;
  logic           alarm;
  logic [CHW-1:0] alarm_ch;
  logic [NCH-1:0] pending;
  logic           busy;
  logic           overrun;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_compare_multi #(
    .NCH      (NCH),
    .TW       (TW),
    .RING_LEN (RL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .cur_time (cur_time),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_time (cfg_time),
    .cfg_en   (cfg_en),
    .ack      (ack),
    .alarm    (alarm),
    .alarm_ch (alarm_ch),
    .pending  (pending),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           we;
    logic [CHW-1:0] ch;
    logic [TW-1:0]  tm;
    logic           en;
    logic           tk;
    logic           ak;
    logic [TW-1:0]  cur;
    logic           ea;
    logic [CHW-1:0] ech;
    logic [NCH-1:0] ep;
    logic           eb;
    logic           eo;
  } vec_t;

  function automatic logic [TW-1:0] hms(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ea, logic [CHW-1:0] ech, logic [NCH-1:0] ep,
                         logic eb, logic eo);
    chk({tag, ".alarm"},    32'(alarm),    32'(ea));
    chk({tag, ".alarm_ch"}, 32'(alarm_ch), 32'(ech));
    chk({tag, ".pending"},  32'(pending),  32'(ep));
    chk({tag, ".busy"},     32'(busy),     32'(eb));
    chk({tag, ".overrun"},  32'(overrun),  32'(eo));
  endtask

  // Advance one clock and sample 1 time unit after the edge, then drop pulse inputs
  task automatic cyc();
    @(posedge clk);
    #1;
    tick   = 1'b0;
    ack    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cfg(int ch, logic [TW-1:0] tm, logic en);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_time = tm;
    cfg_en   = en;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  vec_t tbl [14];

  initial begin
    logic [TW-1:0] t730, t731, t800, t900;
    t730 = hms(7, 30, 0);
    t731 = hms(7, 31, 0);
    t800 = hms(8, 0, 0);
    t900 = hms(9, 0, 0);

    // we ch tm en tick ack cur | alarm ach pend busy ovr
    tbl[0]  = '{1'b1, 2'd2, t730, 1'b1, 1'b0, 1'b0, t730, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, '0,   1'b0, 1'b1, 1'b0, t730, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t730, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t730, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t730, 1'b0, 2'd0, 4'h4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t730, 1'b1, 2'd2, 4'h4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t730, 1'b1, 2'd2, 4'h4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b1, t730, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b1, t730, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, '0,   1'b0, 1'b1, 1'b0, t731, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t731, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t731, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t731, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, '0,   1'b0, 1'b0, 1'b0, t731, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0};

    rst = 1'b1; tick = 1'b0; cur_time = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_time = '0; cfg_en = 1'b0; ack = 1'b0;
    cycn(2);
    rst = 1'b0;
    chk_all("reset", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    // Single match on ch2, ack, ack in QUIET, non-matching scan of exactly NCH cycles
    for (int i = 0; i < 14; i++) begin
      cfg_we   = tbl[i].we;
      cfg_ch   = tbl[i].ch;
      cfg_time = tbl[i].tm;
      cfg_en   = tbl[i].en;
      tick     = tbl[i].tk;
      ack      = tbl[i].ak;
      cur_time = tbl[i].cur;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ech, tbl[i].ep, tbl[i].eb, tbl[i].eo);
    end

    // Timeout: ch2 rings with no ack, falls right after the 8th tick in RING
    cur_time = t730;
    tick = 1'b1;
    cyc();
    cycn(4);
    chk_all("to.ring", 1'b1, 2'd2, 4'h4, 1'b0, 1'b0);
    cur_time = t731;
    for (int k = 1; k <= RL; k++) begin
      tick = 1'b1;
      cyc();
      if (k < RL) begin
        chk($sformatf("to.tick%0d.alarm", k), 32'(alarm), 32'd1);
        cycn(4);
      end else begin
        chk("to.final.alarm", 32'(alarm), 32'd0);
        chk("to.final.pending", 32'(pending), 32'd0);
      end
    end

    // Multiple matches: ch0 and ch3 ring in turn, disabled ch1 never
    do_reset();
    cfg(0, t800, 1'b1);
    cfg(1, t800, 1'b0);
    cfg(3, t800, 1'b1);
    cur_time = t800;
    tick = 1'b1;
    cyc();
    cyc();
    chk_all("mm.e1", 1'b0, 2'd0, 4'h1, 1'b1, 1'b0);
    cyc();
    chk_all("mm.e2", 1'b1, 2'd0, 4'h1, 1'b1, 1'b0);
    cycn(2);
    chk_all("mm.e4", 1'b1, 2'd0, 4'h9, 1'b0, 1'b0);
    ack = 1'b1;
    cyc();
    chk_all("mm.ack0", 1'b0, 2'd0, 4'h8, 1'b0, 1'b0);
    cyc();
    chk_all("mm.ring3", 1'b1, 2'd3, 4'h8, 1'b0, 1'b0);
    ack = 1'b1;
    cyc();
    chk_all("mm.ack3", 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    cycn(3);
    chk_all("mm.quiet", 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);

    // Reconfigure while ringing: disabling ch3 drops the alarm and stops later matches
    cfg(0, t800, 1'b0);
    tick = 1'b1;
    cyc();
    cycn(4);
    chk("rc.pend", 32'(pending), 32'h8);
    cyc();
    chk_all("rc.ring3", 1'b1, 2'd3, 4'h8, 1'b0, 1'b0);
    cfg(3, t800, 1'b0);
    chk("rc.drop.alarm", 32'(alarm), 32'd0);
    chk("rc.drop.pending", 32'(pending), 32'd0);
    tick = 1'b1;
    cyc();
    cycn(5);
    chk_all("rc.later", 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);

    // Overrun plus config-write/scanner-set conflict on ch0
    do_reset();
    cfg(0, t900, 1'b1);
    cur_time = t900;
    tick = 1'b1;
    cyc();
    chk("ov.busy", 32'(busy), 32'd1);
    tick     = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_time = t900;
    cfg_en   = 1'b1;
    cyc();
    chk_all("ov.e1", 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
    cycn(3);
    chk_all("ov.e4", 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
    cycn(2);
    chk_all("ov.after", 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);

    // Reset mid-RING and mid-SCAN aborts everything and clears enables
    tick = 1'b1;
    cyc();
    cyc();
    chk("rs.pend", 32'(pending), 32'h1);
    cyc();
    chk("rs.alarm", 32'(alarm), 32'd1);
    chk("rs.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_all("rs.after", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    cur_time = '0;
    tick = 1'b1;
    cyc();
    cycn(5);
    chk_all("rs.en_zero", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_compare_multi.md
Name: alarm_compare_multi

Overview:
Parametrised successor to the single-timer compare controller. It holds NCH independently programmable alarm times. On every 1 Hz tick it scans all channels against a snapshot of the current time-of-day. Matching enabled channels are queued, and one alarm is presented at a time for a bounded ring duration, with acknowledge. It sits between the time-of-day counter and the buzzer/display mux.

Parameters:
NCH, 4, number of alarm channels (2..16)
TW, 17, time word width (hh 5b : mm 6b : ss 6b, packed binary)
RING_LEN, 8, ring duration in ticks before auto-timeout (1..255)
CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle 1 Hz strobe
cur_time  in  TW  current time-of-day
cfg_we  in  1  config write strobe
cfg_ch  in  CHW  channel being written
cfg_time  in  TW  alarm time for cfg_ch
cfg_en  in  1  enable for cfg_ch
ack  in  1  one-cycle acknowledge of the ringing channel
alarm  out  1  high while a channel rings
alarm_ch  out  CHW  index of the ringing channel
pending  out  NCH  matched, not-yet-serviced channels
busy  out  1  scanner not idle
overrun  out  1  sticky flag: tick arrived while scanning

Behaviour:
- Reset: all alarm times 0, all enables 0, pending=0, alarm=0, alarm_ch=0, busy=0, overrun=0. Both FSMs go to their idle states. Reset mid-scan or mid-ring aborts immediately.
- Config write: cfg_we registers cfg_time/cfg_en into cfg_ch in one cycle. It also clears pending[cfg_ch]. If that channel is ringing, the ringer drops to QUIET on the next cycle.
- Scanner FSM, states IDLE and SCAN:
  - In IDLE, tick latches cur_time into snap, sets idx=0, and goes to SCAN. busy=1 from the next cycle.
  - In SCAN, one channel is compared per cycle. If en[idx] and time[idx]==snap, pending[idx] is set.
  - After idx==NCH-1 the scanner returns to IDLE, so busy lasts exactly NCH cycles.
  - A tick seen in SCAN is dropped and sets overrun. overrun clears only on rst.
  - A config write to a channel not yet reached in the current scan is used by that scan.
- Ringer FSM, states QUIET and RING:
  - In QUIET with pending!=0, the ringer selects the lowest-index pending bit, loads alarm_ch, zeroes cnt, and enters RING on the next cycle.
  - In RING, alarm=1 and each tick increments cnt.
  - ack, or cnt reaching RING_LEN, clears pending[alarm_ch] and returns to QUIET with alarm=0.
  - The next pending channel (if any) rings after exactly one QUIET cycle.
  - ack while in QUIET is ignored.
- Simultaneous events:
  - Scanner set and ringer clear of the same pending bit in one cycle: set wins, and the channel re-rings.
  - cfg_we clear and scanner set on the same channel in one cycle: cfg_we wins.
  - A tick in the same cycle as a ring timeout counts toward cnt before the timeout compare, so the timeout fires on the RING_LEN-th tick.
- Widths:
  - Comparison is exact equality over TW bits; no wrap or tolerance.
  - cnt is $clog2(RING_LEN+1) bits and never wraps.
  - cfg_ch >= NCH is ignored.

Test Plan:
- Reset values: assert rst mid-RING -> next cycle alarm=0, pending=0, busy=0, overrun=0, and all enables read back 0.
- Single match: ch2 = 07:30:00 enabled, cur_time = 07:30:00, tick -> pending[2] set 3 cycles after the tick (NCH=4), then alarm=1 with alarm_ch=2. ack -> alarm=0 next cycle, pending=0.
- Timeout: same setup with no ack and RING_LEN=8 -> alarm falls on the cycle after the 8th tick in RING, and pending[2] clears.
- Multiple matches: ch0, ch1, ch3 match the same time, ch1 disabled -> ch0 rings, ack, one QUIET cycle, then ch3 rings. ch1 never rings.
- Overrun and conflict: tick twice within 4 cycles -> overrun=1 and second tick ignored. Issue cfg_we to ch0 in the same cycle the scanner matches ch0 -> pending[0] stays 0.
- Reconfigure while ringing: ch3 ringing, cfg_we ch3 with en=0 -> alarm=0 within 2 cycles, and ch3 no longer matches on later ticks.
